// File: rtl/regfile_wb_controller_pkg.sv
// rtl/regfile_wb_controller_pkg.sv - shared constants, FSM state type and round-robin helper
package regfile_wb_controller_pkg;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {INIT, RUN} wbc_state_t;

  // First index to examine when the previous winner was ptr.
  function automatic int unsigned rr_start(input int unsigned ptr, input int unsigned n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/regfile_wb_controller_if.sv
// rtl/regfile_wb_controller_if.sv - writeback requests, issue/clear controls and register file write port
interface regfile_wb_controller_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               issue_valid;
  logic [AW-1:0]      issue_reg;
  logic               clear_req;
  logic               regWrite;
  logic [AW-1:0]      writeReg;
  logic [DW-1:0]      writeData;
  logic [31:0]        busy;
  logic               init_done;

  modport master (
    output req_valid, req_reg, req_data, issue_valid, issue_reg, clear_req,
    input  req_ready, regWrite, writeReg, writeData, busy, init_done
  );

  modport slave (
    input  req_valid, req_reg, req_data, issue_valid, issue_reg, clear_req,
    output req_ready, regWrite, writeReg, writeData, busy, init_done
  );
endinterface

// File: rtl/regfile_wb_controller_rr_arbiter.sv
// rtl/regfile_wb_controller_rr_arbiter.sv - combinational round-robin grant from request vector and last-winner pointer
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);
  import regfile_wb_controller_pkg::*;

  logic [PW-1:0] pos;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    pos   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = PW'((rr_start(32'(ptr_i), N) + k) % N);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
    any_o = found;
  end
endmodule

// File: rtl/regfile_wb_controller.sv
// rtl/regfile_wb_controller.sv - register file write-port sequencer: init sweep, round-robin writeback, busy scoreboard
module regfile_wb_controller #(
  parameter int NREQ = 3,
  parameter int AW   = regfile_wb_controller_pkg::AW,
  parameter int DW   = regfile_wb_controller_pkg::DW
) (
  input logic                    clk,
  input logic                    reset,
  regfile_wb_controller_if.slave bus
);
  import regfile_wb_controller_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

  wbc_state_t          state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                regwrite_q, regwrite_d;
  logic [AW-1:0]       writereg_q, writereg_d;
  logic [DW-1:0]       writedata_q, writedata_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                init_done_q, init_done_d;

  logic [NREQ-1:0] gnt, ready;
  logic [PW-1:0]   win_idx;
  logic            win_any;
  logic [AW-1:0]   win_reg;
  logic [DW-1:0]   win_data;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    busy_d      = busy_q;
    ready       = '0;
    win_reg     = bus.req_reg[win_idx*AW +: AW];
    win_data    = bus.req_data[win_idx*DW +: DW];

    // Clear lands with the register file capture; a same-edge set below overrides it.
    if (regwrite_q) busy_d[writereg_q] = 1'b0;

    case (state_q)
      INIT: begin
        if (bus.clear_req) begin
          cnt_d = AW'(1);
        end else begin
          regwrite_d  = 1'b1;
          writereg_d  = cnt_q;
          writedata_d = '0;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_REG) state_d = RUN;
        end
      end
      RUN: begin
        if (bus.clear_req) begin
          state_d = INIT;
          cnt_d   = AW'(1);
          busy_d  = '0;
        end else begin
          ready = gnt;
          if (bus.issue_valid && bus.issue_reg != '0) busy_d[bus.issue_reg] = 1'b1;
          if (win_any) begin
            rr_ptr_d = win_idx;
            // r0 is hardwired: the request is consumed but never written.
            if (win_reg != '0) begin
              regwrite_d  = 1'b1;
              writereg_d  = win_reg;
              writedata_d = win_data;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase

    busy_d[0]   = 1'b0;
    init_done_d = (state_q == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      cnt_q       <= AW'(1);
      rr_ptr_q    <= PW'(NREQ - 1);
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      busy_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.regWrite  = regwrite_q;
  assign bus.writeReg  = writereg_q;
  assign bus.writeData = writedata_q;
  assign bus.busy      = busy_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_regfile_wb_controller.sv
// tb/tb_regfile_wb_controller.sv - self-checking bench for regfile_wb_controller
module tb_regfile_wb_controller;

  typedef struct {
    logic [2:0]      valid;
    logic [2:0][4:0] regs;
    logic [2:0]      exp_ready;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vecs[15];

  regfile_wb_controller_if #(.NREQ(3), .AW(5), .DW(32)) bus ();

  regfile_wb_controller #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [2:0][31:0] dats_of(input logic [2:0][4:0] regs);
    logic [2:0][31:0] d;
    for (int i = 0; i < 3; i++) d[i] = {16'hC0DE, 8'(i), 3'b000, regs[i]};
    return d;
  endfunction

  // Called at a negedge; returns at the following negedge after comparing the write it caused.
  task automatic drive_cycle(input logic [2:0] v, input logic [2:0][4:0] regs,
                             input logic [2:0][31:0] dats, input logic iv, input logic [4:0] ir,
                             input logic clr, input logic [2:0] exp_rdy, input string tag);
    exp_t e;
    bus.req_valid = v;
    for (int i = 0; i < 3; i++) begin
      bus.req_reg[i*5 +: 5]   = regs[i];
      bus.req_data[i*32 +: 32] = dats[i];
    end
    bus.issue_valid = iv;
    bus.issue_reg   = ir;
    bus.clear_req   = clr;
    #1;
    check($sformatf("%s req_ready", tag), 64'(bus.req_ready), 64'(exp_rdy));
    e.wr = 1'b0; e.r = '0; e.d = '0;
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i]) begin
        e.r  = regs[i];
        e.d  = dats[i];
        e.wr = (regs[i] != 5'd0);
      end
    end
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid   = '0;
    bus.issue_valid = 1'b0;
    bus.clear_req   = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("%s regWrite", tag), 64'(bus.regWrite), 64'(e.wr));
    if (e.wr) begin
      check($sformatf("%s writeReg", tag), 64'(bus.writeReg), 64'(e.r));
      check($sformatf("%s writeData", tag), 64'(bus.writeData), 64'(e.d));
    end
  endtask

  task automatic idle(input logic iv, input logic [4:0] ir, input string tag);
    drive_cycle(3'b000, '0, '0, iv, ir, 1'b0, 3'b000, tag);
  endtask

  // Starts at a negedge with the controller in INIT and cnt==1.
  task automatic sweep(input logic [2:0] v, input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      bus.req_valid = v;
      #1;
      check($sformatf("%s ready r%0d", tag, k), 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      check($sformatf("%s regWrite r%0d", tag, k), 64'(bus.regWrite), 64'd1);
      check($sformatf("%s writeReg r%0d", tag, k), 64'(bus.writeReg), 64'(k));
      check($sformatf("%s writeData r%0d", tag, k), 64'(bus.writeData), 64'd0);
    end
    bus.req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'b111, {5'd7, 5'd6, 5'd5}, 3'b001};
    vecs[1]  = '{3'b111, {5'd7, 5'd6, 5'd5}, 3'b010};
    vecs[2]  = '{3'b111, {5'd7, 5'd6, 5'd5}, 3'b100};
    vecs[3]  = '{3'b111, {5'd7, 5'd6, 5'd5}, 3'b001};
    vecs[4]  = '{3'b111, {5'd7, 5'd6, 5'd5}, 3'b010};
    vecs[5]  = '{3'b111, {5'd7, 5'd6, 5'd5}, 3'b100};
    vecs[6]  = '{3'b000, {5'd7, 5'd6, 5'd5}, 3'b000};
    vecs[7]  = '{3'b010, {5'd12, 5'd11, 5'd10}, 3'b010};
    vecs[8]  = '{3'b110, {5'd12, 5'd11, 5'd10}, 3'b100};
    vecs[9]  = '{3'b011, {5'd12, 5'd11, 5'd10}, 3'b001};
    vecs[10] = '{3'b011, {5'd12, 5'd11, 5'd10}, 3'b010};
    vecs[11] = '{3'b101, {5'd12, 5'd11, 5'd10}, 3'b100};
    vecs[12] = '{3'b010, {5'd12, 5'd11, 5'd10}, 3'b010};
    vecs[13] = '{3'b010, {5'd12, 5'd11, 5'd10}, 3'b010};
    vecs[14] = '{3'b101, {5'd12, 5'd11, 5'd10}, 3'b100};

    clk             = 1'b0;
    reset           = 1'b0;
    bus.req_valid   = 3'b111;
    bus.req_reg     = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_reg   = '0;
    bus.clear_req   = 1'b0;

    #12;
    check("reset regWrite", 64'(bus.regWrite), 64'd0);
    check("reset writeReg", 64'(bus.writeReg), 64'd0);
    check("reset writeData", 64'(bus.writeData), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset init_done", 64'(bus.init_done), 64'd0);
    check("reset req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    sweep(3'b111, 31, "init");
    check("init_done after last write", 64'(bus.init_done), 64'd0);
    idle(1'b0, 5'd0, "settle");
    check("init_done rises", 64'(bus.init_done), 64'd1);

    foreach (vecs[n])
      drive_cycle(vecs[n].valid, vecs[n].regs, dats_of(vecs[n].regs), 1'b0, 5'd0, 1'b0,
                  vecs[n].exp_ready, $sformatf("vec%0d", n));
    check("busy after table", 64'(bus.busy), 64'd0);

    idle(1'b1, 5'd9, "issue r9");
    check("busy9 at T+1", 64'(bus.busy[9]), 64'd1);
    idle(1'b0, 5'd0, "wait1");
    check("busy9 at T+2", 64'(bus.busy[9]), 64'd1);
    idle(1'b0, 5'd0, "wait2");
    drive_cycle(3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 5'd0, 1'b0,
                3'b001, "wb r9");
    check("busy9 at T+4", 64'(bus.busy[9]), 64'd1);
    idle(1'b0, 5'd0, "wait3");
    check("busy9 at T+5", 64'(bus.busy[9]), 64'd0);

    idle(1'b1, 5'd4, "issue r4");
    check("busy4 set", 64'(bus.busy), 64'h10);
    drive_cycle(3'b010, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h4444, 32'h0}, 1'b0, 5'd0, 1'b0,
                3'b010, "wb r4");
    idle(1'b1, 5'd4, "reissue r4");
    check("busy4 set wins", 64'(bus.busy), 64'h10);

    drive_cycle(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 1'b0, 5'd0, 1'b0,
                3'b010, "wb r0");
    check("busy after r0 write", 64'(bus.busy), 64'h10);

    drive_cycle(3'b100, {5'd3, 5'd0, 5'd0}, {32'h3333, 32'h0, 32'h0}, 1'b0, 5'd0, 1'b1,
                3'b000, "clear");
    check("busy after clear", 64'(bus.busy), 64'd0);
    check("init_done after clear", 64'(bus.init_done), 64'd0);
    sweep(3'b100, 31, "resweep");
    idle(1'b0, 5'd0, "settle2");
    check("init_done after resweep", 64'(bus.init_done), 64'd1);

    drive_cycle(3'b000, '0, '0, 1'b0, 5'd0, 1'b1, 3'b000, "clear2");
    sweep(3'b111, 10, "partial");
    #2;
    reset = 1'b0;
    #1;
    check("async regWrite", 64'(bus.regWrite), 64'd0);
    check("async writeReg", 64'(bus.writeReg), 64'd0);
    check("async writeData", 64'(bus.writeData), 64'd0);
    check("async busy", 64'(bus.busy), 64'd0);
    check("async init_done", 64'(bus.init_done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    sweep(3'b000, 31, "post reset");
    drive_cycle(3'b111, {5'd23, 5'd22, 5'd21}, dats_of({5'd23, 5'd22, 5'd21}), 1'b0, 5'd0,
                1'b0, 3'b001, "ptr reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
